store_queue: RTL and testbench

- In-order store buffer between dispatch/FU Mem and data memory.
- Allocates one entry per dispatched store. Captures address and data from FU Mem and holds each store until the ROB commits it.
- Drains committed stores to data memory one per cycle as a single-cycle write strobe.
- Tells FU Mem when a load must stall because of a possible conflict with a buffered store.

---
 rtl/store_queue.sv | 186 ++++++++++++++++++
 tb/tb_store_queue.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue.sv
// store_queue
// In-order store buffer between dispatch / FU Mem and data memory.
//
// Each dispatched store gets one entry at the tail. FU Mem fills in the
// address and data later. The ROB commits the store by its tag. The entry at
// the head is written to memory once it is committed and has its address; the
// write shows up as a registered, one-cycle strobe.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   alloc_valid/_rob_tag/_is_sh      dispatch request for a new entry
//   alloc_ready, alloc_idx           entry available / index (tail) handed out
//   exe_valid/_idx/_addr/_data       resolved address and data for an entry
//   commit_valid, commit_rob_tag     ROB retires the store with this tag
//   flush                            discard every uncommitted entry
//   ld_check_valid, ld_check_addr    load probe
//   ld_block                         load must wait (combinational)
//   store_wb, st_addr/_data/_is_sh   registered write strobe to data memory
//   empty                            no valid entries
module store_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 5,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic [TAG_W-1:0] alloc_rob_tag,
  input  logic             alloc_is_sh,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             exe_valid,
  input  logic [IDX_W-1:0] exe_idx,
  input  logic [31:0]      exe_addr,
  input  logic [31:0]      exe_data,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_rob_tag,
  input  logic             flush,
  input  logic             ld_check_valid,
  input  logic [31:0]      ld_check_addr,
  output logic             ld_block,
  output logic             store_wb,
  output logic [31:0]      st_addr,
  output logic [31:0]      st_data,
  output logic             st_is_sh,
  output logic             empty
);

  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] addr_rdy;
  logic [DEPTH-1:0] committed;
  logic [DEPTH-1:0] is_sh;
  logic [TAG_W-1:0] rob_tag [DEPTH];
  logic [31:0]      addr    [DEPTH];
  logic [31:0]      data    [DEPTH];

  logic             alloc_fire;
  logic             drain_fire;
  logic             exe_ok;
  logic             commit_hit;
  logic [IDX_W-1:0] commit_idx;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W:0]   n_comm;

  // Loads compare on word granularity, so the byte offset never matters.
  logic unused_ld_lsb;
  assign unused_ld_lsb = ^ld_check_addr[1:0];

  // A full queue stays not-ready for the cycle in which it drains.
  assign alloc_ready = (count < DEPTH_CNT) && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_idx   = tail;
  assign empty       = (count == '0);
  assign drain_fire  = valid[head] && committed[head] && addr_rdy[head];

  // Committed entries survive a flush, so they can still take their address.
  assign exe_ok = exe_valid && valid[exe_idx] && (committed[exe_idx] || !flush);

  // Scan from head to find the oldest uncommitted match. Also count the
  // committed entries. Commits are in order, so those entries sit
  // contiguously from head.
  always_comb begin
    commit_hit = 1'b0;
    commit_idx = '0;
    scan_idx   = '0;
    n_comm     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + IDX_W'(i);
      if (!commit_hit && valid[scan_idx] && !committed[scan_idx] &&
          rob_tag[scan_idx] == commit_rob_tag) begin
        commit_hit = 1'b1;
        commit_idx = scan_idx;
      end
      n_comm = n_comm + (IDX_W+1)'(valid[i] & committed[i]);
    end
  end

  // Every buffered store is older than the probing load.
  always_comb begin
    ld_block = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ld_check_valid && valid[i] &&
          (!addr_rdy[i] || addr[i][31:2] == ld_check_addr[31:2]))
        ld_block = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (drain_fire)
        head <= head + IDX_W'(1);
      if (flush) begin
        // n_comm still includes an entry that drains this cycle.
        // Measure from the old head and remove that entry from the count.
        tail  <= head + n_comm[IDX_W-1:0];
        count <= n_comm - (IDX_W+1)'(drain_fire);
      end else begin
        if (alloc_fire)
          tail <= tail + IDX_W'(1);
        count <= count + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(drain_fire);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid     <= '0;
      addr_rdy  <= '0;
      committed <= '0;
      is_sh     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_tag[i] <= '0;
        addr[i]    <= '0;
        data[i]    <= '0;
      end
    end else begin
      if (exe_ok) begin
        addr[exe_idx]     <= exe_addr;
        data[exe_idx]     <= exe_data;
        addr_rdy[exe_idx] <= 1'b1;
      end
      // The flush discards every uncommitted entry.
      // A commit that arrives in the same cycle as the flush has nothing left to mark.
      if (commit_valid && commit_hit && !flush)
        committed[commit_idx] <= 1'b1;
      if (flush)
        valid <= valid & committed;
      if (drain_fire)
        valid[head] <= 1'b0;
      if (alloc_fire) begin
        valid[tail]     <= 1'b1;
        addr_rdy[tail]  <= 1'b0;
        committed[tail] <= 1'b0;
        is_sh[tail]     <= alloc_is_sh;
        rob_tag[tail]   <= alloc_rob_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_wb <= 1'b0;
      st_addr  <= '0;
      st_data  <= '0;
      st_is_sh <= 1'b0;
    end else begin
      store_wb <= drain_fire;
      if (drain_fire) begin
        st_addr  <= addr[head];
        st_data  <= data[head];
        st_is_sh <= is_sh[head];
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed testbench for store_queue (DEPTH = 8, TAG_W = 5).
module tb_store_queue;
  localparam int DEPTH = 8;
  localparam int TAG_W = 5;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             alloc_valid;
  logic [TAG_W-1:0] alloc_rob_tag;
  logic             alloc_is_sh;
  logic             alloc_ready;
  logic [IDX_W-1:0] alloc_idx;
  logic             exe_valid;
  logic [IDX_W-1:0] exe_idx;
  logic [31:0]      exe_addr;
  logic [31:0]      exe_data;
  logic             commit_valid;
  logic [TAG_W-1:0] commit_rob_tag;
  logic             flush;
  logic             ld_check_valid;
  logic [31:0]      ld_check_addr;
  logic             ld_block;
  logic             store_wb;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             st_is_sh;
  logic             empty;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  store_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_rob_tag(alloc_rob_tag), .alloc_is_sh(alloc_is_sh),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .exe_valid(exe_valid), .exe_idx(exe_idx), .exe_addr(exe_addr), .exe_data(exe_data),
    .commit_valid(commit_valid), .commit_rob_tag(commit_rob_tag), .flush(flush),
    .ld_check_valid(ld_check_valid), .ld_check_addr(ld_check_addr), .ld_block(ld_block),
    .store_wb(store_wb), .st_addr(st_addr), .st_data(st_data), .st_is_sh(st_is_sh),
    .empty(empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_rob_tag = '0; alloc_is_sh = 0;
    exe_valid = 0; exe_idx = '0; exe_addr = '0; exe_data = '0;
    commit_valid = 0; commit_rob_tag = '0; flush = 0;
    ld_check_valid = 0; ld_check_addr = '0;
  endtask

  task automatic apply_reset();
    reset = 1;
    idle();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    ld_check_valid = 1; ld_check_addr = 32'h0;
    #2;
    n_total++; if (store_wb !== 1'b0) $display("FAIL rst_store_wb: got %b want 0", store_wb); else n_pass++;
    n_total++; if (st_addr !== 32'h0) $display("FAIL rst_st_addr: got %h want 0", st_addr); else n_pass++;
    n_total++; if (st_data !== 32'h0) $display("FAIL rst_st_data: got %h want 0", st_data); else n_pass++;
    n_total++; if (st_is_sh !== 1'b0) $display("FAIL rst_st_is_sh: got %b want 0", st_is_sh); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else n_pass++;
    n_total++; if (ld_block !== 1'b0) $display("FAIL rst_ld_block: got %b want 0", ld_block); else n_pass++;
    n_total++; if (alloc_ready !== 1'b1) $display("FAIL rst_alloc_ready: got %b want 1", alloc_ready); else n_pass++;
    n_total++; if (alloc_idx !== 3'd0) $display("FAIL rst_alloc_idx: got %0d want 0", alloc_idx); else n_pass++;
    tick();
    tick();
    reset = 0;
    idle();
  endtask

  task automatic test_basic();
    alloc_valid = 1; alloc_rob_tag = 5'd3; alloc_is_sh = 0;
    #1;
    n_total++; if (alloc_idx !== 3'd0) $display("FAIL basic_alloc_idx: got %0d want 0", alloc_idx); else n_pass++;
    tick();
    alloc_valid = 0;
    n_total++; if (empty !== 1'b0) $display("FAIL basic_not_empty: got %b want 0", empty); else n_pass++;
    exe_valid = 1; exe_idx = 3'd0; exe_addr = 32'h100; exe_data = 32'hDEADBEEF;
    tick();
    exe_valid = 0;
    // A tag that matches no entry must leave the queue unchanged.
    commit_valid = 1; commit_rob_tag = 5'd4;
    tick();
    commit_valid = 0;
    tick();
    n_total++; if (store_wb !== 1'b0) $display("FAIL basic_nomatch_wb: got %b want 0", store_wb); else n_pass++;
    n_total++; if (empty !== 1'b0) $display("FAIL basic_nomatch_empty: got %b want 0", empty); else n_pass++;
    commit_valid = 1; commit_rob_tag = 5'd3;
    tick();
    commit_valid = 0;
    n_total++; if (store_wb !== 1'b0) $display("FAIL basic_wb_early: got %b want 0", store_wb); else n_pass++;
    tick();
    n_total++; if (store_wb !== 1'b1) $display("FAIL basic_wb: got %b want 1", store_wb); else n_pass++;
    n_total++; if (st_addr !== 32'h100) $display("FAIL basic_st_addr: got %h want 100", st_addr); else n_pass++;
    n_total++; if (st_data !== 32'hDEADBEEF) $display("FAIL basic_st_data: got %h want deadbeef", st_data); else n_pass++;
    n_total++; if (st_is_sh !== 1'b0) $display("FAIL basic_st_is_sh: got %b want 0", st_is_sh); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL basic_empty: got %b want 1", empty); else n_pass++;
    tick();
    n_total++; if (store_wb !== 1'b0) $display("FAIL basic_wb_pulse: got %b want 0", store_wb); else n_pass++;
    n_total++; if (st_addr !== 32'h100) $display("FAIL basic_st_hold: got %h want 100", st_addr); else n_pass++;
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      alloc_valid = 1; alloc_rob_tag = 5'(10 + i); alloc_is_sh = i[0];
      #1;
      n_total++; if (alloc_idx !== 3'(i)) $display("FAIL full_alloc_idx%0d: got %0d want %0d", i, alloc_idx, i); else n_pass++;
      tick();
    end
    // The ninth request stays asserted for one cycle and must be ignored.
    alloc_rob_tag = 5'd20; alloc_is_sh = 1;
    #1;
    n_total++; if (alloc_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", alloc_ready); else n_pass++;
    n_total++; if (alloc_idx !== 3'd0) $display("FAIL full_tail_wrap: got %0d want 0", alloc_idx); else n_pass++;
    tick();
    alloc_valid = 0;
    n_total++; if (dut.count !== 4'd8) $display("FAIL full_count: got %0d want 8", dut.count); else n_pass++;
    exe_valid = 1; exe_idx = 3'd0; exe_addr = 32'h300; exe_data = 32'h11111111;
    tick();
    exe_valid = 0;
    commit_valid = 1; commit_rob_tag = 5'd10;
    tick();
    commit_valid = 0;
    n_total++; if (alloc_ready !== 1'b0) $display("FAIL full_no_bypass: got %b want 0", alloc_ready); else n_pass++;
    tick();
    n_total++; if (store_wb !== 1'b1) $display("FAIL full_drain_wb: got %b want 1", store_wb); else n_pass++;
    n_total++; if (st_addr !== 32'h300) $display("FAIL full_drain_addr: got %h want 300", st_addr); else n_pass++;
    n_total++; if (alloc_ready !== 1'b1) $display("FAIL full_ready_after: got %b want 1", alloc_ready); else n_pass++;
    n_total++; if (alloc_idx !== 3'd0) $display("FAIL full_next_idx: got %0d want 0", alloc_idx); else n_pass++;
    flush = 1;
    tick();
    flush = 0;
    n_total++; if (empty !== 1'b1) $display("FAIL full_flush_empty: got %b want 1", empty); else n_pass++;
    n_total++; if (alloc_idx !== 3'd1) $display("FAIL full_flush_tail: got %0d want 1", alloc_idx); else n_pass++;
  endtask

  task automatic test_ld_block();
    alloc_valid = 1; alloc_rob_tag = 5'd5; alloc_is_sh = 0;
    tick();
    alloc_valid = 0;
    ld_check_valid = 1; ld_check_addr = 32'h104;
    #1;
    n_total++; if (ld_block !== 1'b1) $display("FAIL ld_no_addr: got %b want 1", ld_block); else n_pass++;
    exe_valid = 1; exe_idx = 3'd1; exe_addr = 32'h200; exe_data = 32'h5;
    tick();
    exe_valid = 0;
    n_total++; if (ld_block !== 1'b0) $display("FAIL ld_other_word: got %b want 0", ld_block); else n_pass++;
    ld_check_addr = 32'h202;
    #1;
    n_total++; if (ld_block !== 1'b1) $display("FAIL ld_same_word: got %b want 1", ld_block); else n_pass++;
    ld_check_addr = 32'h204;
    #1;
    n_total++; if (ld_block !== 1'b0) $display("FAIL ld_next_word: got %b want 0", ld_block); else n_pass++;
    ld_check_valid = 0; ld_check_addr = 32'h200;
    #1;
    n_total++; if (ld_block !== 1'b0) $display("FAIL ld_no_probe: got %b want 0", ld_block); else n_pass++;
    flush = 1;
    tick();
    flush = 0;
    n_total++; if (empty !== 1'b1) $display("FAIL ld_flush_empty: got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_flush();
    // head = tail = 1 here; entries go to indices 1..4
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1; alloc_rob_tag = 5'(1 + i); alloc_is_sh = (i == 0);
      tick();
    end
    alloc_valid = 0;
    commit_valid = 1; commit_rob_tag = 5'd1;
    tick();
    commit_rob_tag = 5'd2;
    tick();
    commit_valid = 0;
    n_total++; if (dut.count !== 4'd4) $display("FAIL flush_pre_count: got %0d want 4", dut.count); else n_pass++;
    flush = 1;
    alloc_valid = 1; alloc_rob_tag = 5'd9;
    exe_valid = 1; exe_idx = 3'd3; exe_addr = 32'h30; exe_data = 32'h3;
    #1;
    n_total++; if (alloc_ready !== 1'b0) $display("FAIL flush_alloc_blocked: got %b want 0", alloc_ready); else n_pass++;
    tick();
    idle();
    n_total++; if (dut.count !== 4'd2) $display("FAIL flush_count: got %0d want 2", dut.count); else n_pass++;
    n_total++; if (alloc_idx !== 3'd3) $display("FAIL flush_tail: got %0d want 3", alloc_idx); else n_pass++;
    n_total++; if (empty !== 1'b0) $display("FAIL flush_not_empty: got %b want 0", empty); else n_pass++;
    exe_valid = 1; exe_idx = 3'd2; exe_addr = 32'h20; exe_data = 32'hBBBB;
    tick();
    exe_idx = 3'd1; exe_addr = 32'h10; exe_data = 32'hAAAA;
    tick();
    exe_valid = 0;
    n_total++; if (store_wb !== 1'b0) $display("FAIL flush_wb_early: got %b want 0", store_wb); else n_pass++;
    tick();
    n_total++; if (store_wb !== 1'b1) $display("FAIL flush_wb1: got %b want 1", store_wb); else n_pass++;
    n_total++; if (st_addr !== 32'h10) $display("FAIL flush_addr1: got %h want 10", st_addr); else n_pass++;
    n_total++; if (st_data !== 32'hAAAA) $display("FAIL flush_data1: got %h want aaaa", st_data); else n_pass++;
    n_total++; if (st_is_sh !== 1'b1) $display("FAIL flush_sh1: got %b want 1", st_is_sh); else n_pass++;
    tick();
    n_total++; if (store_wb !== 1'b1) $display("FAIL flush_wb2: got %b want 1", store_wb); else n_pass++;
    n_total++; if (st_addr !== 32'h20) $display("FAIL flush_addr2: got %h want 20", st_addr); else n_pass++;
    n_total++; if (st_is_sh !== 1'b0) $display("FAIL flush_sh2: got %b want 0", st_is_sh); else n_pass++;
    tick();
    n_total++; if (store_wb !== 1'b0) $display("FAIL flush_wb_end: got %b want 0", store_wb); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL flush_empty: got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; alloc_rob_tag = 5'(6 + i); alloc_is_sh = 0;
      tick();
    end
    alloc_valid = 0;
    exe_valid = 1; exe_idx = 3'd0; exe_addr = 32'h40; exe_data = 32'h44;
    tick();
    exe_valid = 0;
    commit_valid = 1; commit_rob_tag = 5'd6;
    tick();
    commit_valid = 0;
    n_total++; if (dut.count !== 4'd3) $display("FAIL b2b_pre_count: got %0d want 3", dut.count); else n_pass++;
    alloc_valid = 1; alloc_rob_tag = 5'd9; alloc_is_sh = 1;
    #1;
    n_total++; if (alloc_idx !== 3'd3) $display("FAIL b2b_alloc_idx: got %0d want 3", alloc_idx); else n_pass++;
    tick();
    alloc_valid = 0;
    n_total++; if (dut.count !== 4'd3) $display("FAIL b2b_count: got %0d want 3", dut.count); else n_pass++;
    n_total++; if (store_wb !== 1'b1) $display("FAIL b2b_wb: got %b want 1", store_wb); else n_pass++;
    n_total++; if (st_addr !== 32'h40) $display("FAIL b2b_addr: got %h want 40", st_addr); else n_pass++;
    n_total++; if (alloc_idx !== 3'd4) $display("FAIL b2b_tail: got %0d want 4", alloc_idx); else n_pass++;
    n_total++; if (dut.head !== 3'd1) $display("FAIL b2b_head: got %0d want 1", dut.head); else n_pass++;
    n_total++; if (dut.valid !== 8'b0000_1110) $display("FAIL b2b_valid: got %b want 00001110", dut.valid); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    exe_valid = 1; exe_idx = 3'd1; exe_addr = 32'h50; exe_data = 32'h55;
    tick();
    exe_valid = 0;
    commit_valid = 1; commit_rob_tag = 5'd7;
    tick();
    commit_valid = 0;
    // Entry 1 is now eligible at head; reset lands before the edge that would strobe.
    reset = 1;
    #1;
    n_total++; if (store_wb !== 1'b0) $display("FAIL rmd_wb: got %b want 0", store_wb); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL rmd_empty: got %b want 1", empty); else n_pass++;
    n_total++; if (alloc_idx !== 3'd0) $display("FAIL rmd_alloc_idx: got %0d want 0", alloc_idx); else n_pass++;
    n_total++; if (st_addr !== 32'h0) $display("FAIL rmd_st_addr: got %h want 0", st_addr); else n_pass++;
    tick();
    n_total++; if (store_wb !== 1'b0) $display("FAIL rmd_wb_held: got %b want 0", store_wb); else n_pass++;
    reset = 0;
    tick();
    n_total++; if (store_wb !== 1'b0) $display("FAIL rmd_wb_after: got %b want 0", store_wb); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL rmd_empty_after: got %b want 1", empty); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_ld_block();
    test_flush();
    test_back_to_back();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
